// File: rtl/sram_lb_pkg.sv
// Shared types and width helper for the SRAM-backed line buffer.
package sram_lb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    OUT  = 2'd3
  } lb_state_e;

  // Bits needed to index n items, never less than one.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_sp_model.sv
// Generic single-port synchronous SRAM, one-cycle read latency; stands in for the foundry macro.
module sram_sp_model
  import sram_lb_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int AW     = width_of(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read data only updates on a read; a write leaves q untouched.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    q         <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_line_buffer.sv
// Line-buffer controller: keeps NUM_LINES-1 lines in a single-port SRAM ring and
// emits, per accepted pixel, the vertical column of NUM_LINES pixels.
module sram_line_buffer
  import sram_lb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LINE_W    = 128,
  parameter int NUM_LINES = 3,
  parameter int ADDR_W    = width_of(LINE_W*(NUM_LINES-1)),
  parameter int COL_W     = width_of(LINE_W)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W*NUM_LINES-1:0] out_col,
  output logic [COL_W-1:0]            out_col_idx,
  output logic                        out_full
);

  localparam int N     = NUM_LINES - 1;
  localparam int KW    = width_of(NUM_LINES);
  localparam int SW    = width_of(N);
  localparam int DEPTH = LINE_W * N;

  localparam logic [KW-1:0]    K_TOP  = KW'(N);
  localparam logic [SW-1:0]    S_TOP  = SW'(N - 1);
  localparam logic [COL_W-1:0] C_LAST = COL_W'(LINE_W - 1);

  lb_state_e                         state;
  logic [KW-1:0]                     k;
  logic [SW-1:0]                     wl;
  logic [COL_W-1:0]                  c;
  logic [KW-1:0]                     f;
  logic [DATA_W-1:0]                 pix;
  logic [NUM_LINES-1:0][DATA_W-1:0]  col_q;

  logic [SW-1:0]     rd_slot;
  logic [SW-1:0]     slot;
  logic [ADDR_W-1:0] addr;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] q;
  logic              cap_en;
  logic [KW-1:0]     cap_k;

  // (wl - k) mod N via compare-and-subtract; N need not be a power of two.
  always_comb begin
    int t;
    t = int'(wl) + N - int'(k);
    if (t >= N) t = t - N;
    rd_slot = SW'(t);
  end

  always_comb begin
    slot   = (state == WR) ? wl : rd_slot;
    addr   = ADDR_W'(slot) * ADDR_W'(LINE_W) + ADDR_W'(c);
    mem_en = (state == RD) || (state == WR);
    mem_we = (state == WR);
  end

  // Q lands one cycle after its read: row k+1 while still in RD, row 1 in WR.
  always_comb begin
    cap_en = ((state == RD) && (k != K_TOP)) || (state == WR);
    cap_k  = (state == WR) ? KW'(1) : k + KW'(1);
  end

  sram_sp_model #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (addr),
    .wdata (pix),
    .q     (q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      k           <= '0;
      wl          <= '0;
      c           <= '0;
      f           <= '0;
      pix         <= '0;
      col_q       <= '0;
      out_col_idx <= '0;
      out_full    <= 1'b0;
    end else if (clr) begin
      // SRAM keeps stale lines; the fill count masks them out.
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      k         <= '0;
      wl        <= '0;
      c         <= '0;
      f         <= '0;
    end else begin
      if (cap_en) col_q[cap_k] <= (cap_k <= f) ? q : '0;
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            pix      <= in_data;
            k        <= K_TOP;
            in_ready <= 1'b0;
            state    <= RD;
          end
        end
        RD: begin
          k <= k - KW'(1);
          if (k == KW'(1)) state <= WR;
        end
        WR: begin
          col_q[0]    <= pix;
          out_col_idx <= c;
          out_full    <= (f == K_TOP);
          out_valid   <= 1'b1;
          if (c == C_LAST) begin
            c  <= '0;
            wl <= (wl == S_TOP) ? '0 : wl + SW'(1);
            if (f != K_TOP) f <= f + KW'(1);
          end else begin
            c <= c + COL_W'(1);
          end
          state <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_col = col_q;

endmodule
